// File: rtl/grf_pkg.sv
// grf_pkg: shared GRF write-port constants and the write record used by writeback sources
//   GRF_AW       register address width
//   GRF_DW       register data width
//   GRF_ZERO_REG hard-wired zero register; writes to it are dropped
//   grf_wr_t     {addr, data} write record
package grf_pkg;
   localparam int GRF_AW = 5;
   localparam int GRF_DW = 32;
   localparam logic [GRF_AW-1:0] GRF_ZERO_REG = 5'd0;
   typedef struct packed {
      logic [GRF_AW-1:0] addr;
      logic [GRF_DW-1:0] data;
   } grf_wr_t;
endpackage

// File: rtl/grf_write_arbiter_if.sv
// grf_write_arbiter_if: requester bundle and GRF write port of grf_write_arbiter
//   req_valid/req_ready  per-requester handshake (NREQ bits)
//   req_addr/req_data    packed requester slices, slice i at [i*AW +: AW] / [i*DW +: DW]
//   grf_stall            freezes the GRF write port
//   Enabled/A3/WD3       GRF write port
//   busy/wr_count        output stage occupancy and retired-write count
//   modport master: requesters + GRF side; modport slave: the arbiter
interface grf_write_arbiter_if
   import grf_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = GRF_AW,
   parameter int DW   = GRF_DW,
   parameter int CW   = 16
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic               grf_stall;
   logic               Enabled;
   logic [AW-1:0]      A3;
   logic [DW-1:0]      WD3;
   logic               busy;
   logic [CW-1:0]      wr_count;
   modport master (
      output req_valid, req_addr, req_data, grf_stall,
      input  req_ready, Enabled, A3, WD3, busy, wr_count
   );
   modport slave (
      input  req_valid, req_addr, req_data, grf_stall,
      output req_ready, Enabled, A3, WD3, busy, wr_count
   );
endinterface

// File: rtl/grf_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first set req bit scanning ptr, ptr+1, ... mod N
//   req  in  N   request vector
//   ptr  in  PW  highest-priority index this cycle
//   en   in  1   grant enable; gnt is 0 when low
//   gnt  out N   one-hot grant or 0
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt
);
   int   idx;
   logic found;
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: round-robin sharing of the single GRF write port among NREQ requesters
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    slave modport of grf_write_arbiter_if (requester handshakes, grf_stall,
//          Enabled/A3/WD3 write port, busy, wr_count)
//   Optional macro GRF_ARB_PRIO0_EN: requester 0 gets strict priority and its grants
//   leave the round-robin pointer untouched.
module grf_write_arbiter
   import grf_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = GRF_AW,
   parameter int DW   = GRF_DW,
   parameter int CW   = 16
) (
   input logic                clk,
   input logic                reset,
   grf_write_arbiter_if.slave bus
);
`ifdef GRF_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            busy_q, busy_d;
   logic [AW-1:0]   a3_q, a3_d;
   logic [DW-1:0]   wd3_q, wd3_d;
   logic [CW-1:0]   wr_count_q, wr_count_d;
   logic            grant_en, xfer, wr_en;
   logic [NREQ-1:0] rr_req, rr_gnt, gnt;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   // A request is taken when the output stage is empty or retires this cycle.
   assign grant_en = (~busy_q | ~bus.grf_stall) & ~reset;
   // In priority mode requester 0 bypasses the round robin entirely.
   assign rr_req = PRIO0 ? (bus.req_valid & ~NREQ'(1)) : bus.req_valid;
   assign gnt    = (PRIO0 && bus.req_valid[0]) ? NREQ'(1) : rr_gnt;
   rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
      .req (rr_req),
      .ptr (rr_ptr_q),
      .en  (grant_en),
      .gnt (rr_gnt)
   );
   assign bus.req_ready = gnt & {NREQ{grant_en}};
   assign xfer          = |bus.req_ready;
   // Reset also suppresses the write of whatever the output stage still holds.
   assign wr_en         = busy_q & ~bus.grf_stall & ~reset;
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      rr_ptr_d = rr_ptr_q;
      for (int k = 0; k < NREQ; k++) begin
         if (bus.req_ready[k]) begin
            sel_addr = bus.req_addr[k*AW +: AW];
            sel_data = bus.req_data[k*DW +: DW];
            rr_ptr_d = (PRIO0 && k == 0) ? rr_ptr_q : PW'((k + 1) % NREQ);
         end
      end
   end
   // Writes to the zero register complete the handshake but never occupy the stage.
   always_comb begin
      busy_d     = xfer ? (sel_addr != AW'(GRF_ZERO_REG)) : (busy_q & bus.grf_stall);
      a3_d       = xfer ? sel_addr : a3_q;
      wd3_d      = xfer ? sel_data : wd3_q;
      wr_count_d = wr_count_q + CW'(wr_en);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         busy_q     <= 1'b0;
         a3_q       <= '0;
         wd3_q      <= '0;
         wr_count_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         busy_q     <= busy_d;
         a3_q       <= a3_d;
         wd3_q      <= wd3_d;
         wr_count_q <= wr_count_d;
      end
   end
   assign bus.Enabled  = wr_en;
   assign bus.A3       = a3_q;
   assign bus.WD3      = wd3_q;
   assign bus.busy     = busy_q;
   assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_grf_write_arbiter.sv
// tb_grf_write_arbiter: scoreboard bench for grf_write_arbiter (NREQ=4, CW=4 so wr_count wraps quickly)
module tb_grf_write_arbiter;
   import grf_pkg::*;
`ifdef GRF_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif
   logic      clk = 1'b0;
   logic      reset = 1'b1;
   int        checks = 0;
   int        failures = 0;
   grf_wr_t   sbq[$];
   logic      m_busy = 1'b0;
   logic [1:0] m_ptr = 2'd0;
   logic [3:0] m_count = 4'd0;
   logic [4:0]  a[4];
   logic [31:0] d[4];
   int        cyc = 0;
   int        last_g[4];
   bit        fair_on = 1'b0;
   always #5 clk = ~clk;
   grf_write_arbiter_if #(.NREQ(4), .AW(5), .DW(32), .CW(4)) bus ();
   grf_write_arbiter #(.NREQ(4), .AW(5), .DW(32), .CW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic int model_grant(input logic [3:0] v, input logic [1:0] p);
      if (PRIO0 && v[0]) return 0;
      if (PRIO0) v[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (v[(int'(p) + k) % 4]) return (int'(p) + k) % 4;
      end
      return -1;
   endfunction
   task automatic step(input logic [3:0] v, input logic stall, input logic rst_i);
      int g;
      logic [3:0] er;
      logic ee;
      grf_wr_t w;
      reset = rst_i;
      bus.grf_stall = stall;
      bus.req_valid = v;
      for (int k = 0; k < 4; k++) begin
         bus.req_addr[k*5 +: 5]   = a[k];
         bus.req_data[k*32 +: 32] = d[k];
      end
      @(negedge clk);
      g  = ((!m_busy || !stall) && !rst_i) ? model_grant(v, m_ptr) : -1;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ee = m_busy && !stall && !rst_i;
      check("req_ready", 64'(bus.req_ready), 64'(er));
      check("Enabled", 64'(bus.Enabled), 64'(ee));
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("wr_count", 64'(bus.wr_count), 64'(m_count));
      if (bus.Enabled) begin
         if (sbq.size() == 0) check("sb_empty", 64'(sbq.size()), 64'd1);
         else begin
            w = sbq.pop_front();
            check("A3", 64'(bus.A3), 64'(w.addr));
            check("WD3", 64'(bus.WD3), 64'(w.data));
         end
      end
      if (fair_on && g >= 0) begin
         check("starve", 64'(cyc - last_g[g] <= 4), 64'd1);
         last_g[g] = cyc;
      end
      if (rst_i) begin
         m_busy = 1'b0;
         m_ptr = 2'd0;
         m_count = 4'd0;
         sbq.delete();
      end else begin
         if (ee) m_count++;
         if (g >= 0) begin
            w.addr = a[g];
            w.data = d[g];
            m_busy = (a[g] != 5'd0);
            if (m_busy) sbq.push_back(w);
            if (!(PRIO0 && g == 0)) m_ptr = 2'((g + 1) % 4);
            d[g] = $urandom;
         end else if (!stall) m_busy = 1'b0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int k = 0; k < 4; k++) begin
         a[k] = 5'(k + 1);
         d[k] = $urandom;
      end
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.grf_stall = 1'b0;
      @(posedge clk);
      #1;
      // reset with every requester valid
      step(4'hf, 1'b0, 1'b1);
      step(4'hf, 1'b0, 1'b1);
      check("A3_rst", 64'(bus.A3), 64'd0);
      check("WD3_rst", 64'(bus.WD3), 64'd0);
      // single write
      a[0] = 5'd2;
      d[0] = 32'd16499;
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      // fairness from a fresh pointer
      step(4'b0000, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         a[k] = 5'(k + 1);
         last_g[k] = cyc;
      end
      fair_on = 1'b1;
      repeat (8) step(4'hf, 1'b0, 1'b0);
      fair_on = 1'b0;
      step(4'b0000, 1'b0, 1'b0);
      // zero register
      a[1] = 5'd0;
      d[1] = 32'd165464;
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      // stall while busy, requester 3 waiting
      a[2] = 5'd5;
      a[3] = 5'd6;
      step(4'b0100, 1'b0, 1'b0);
      repeat (3) begin
         step(4'b1000, 1'b1, 1'b0);
         check("A3_hold", 64'(bus.A3), 64'd5);
      end
      step(4'b1000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      // stall while empty still accepts one
      a[0] = 5'd3;
      step(4'b0001, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      // reset right after acceptance
      a[0] = 5'd7;
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b0);
      a[0] = 5'd1;
      repeat (4) step(4'hf, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      // wr_count wrap
      a[0] = 5'd9;
      repeat (20) step(4'b0001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      check("sb_drained", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
